ee354_ssd_scan_driver: RTL and testbench
========================================

EE354_SSD_SCAN_DRIVER -- requirements
Module: ee354_ssd_scan_driver

Interface
REQ-001 The module SHALL have parameter SCAN_DIV_BITS, default 18, giving a digit slot length of 2^SCAN_DIV_BITS clocks.
REQ-002 The module SHALL have parameter DEAD_CYC, default 256, giving the all-anodes-off cycles at the start of each slot; legal range is 1 .. 2^SCAN_DIV_BITS-1.
REQ-003 The module SHALL have port Clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The module SHALL have port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port Load, input, 1 bit: single-clock strobe that stages Digits for display.
REQ-006 The module SHALL have port Digits, input, 16 bits: [15:12]=digit3 (leftmost) .. [3:0]=digit0 (rightmost), hex.
REQ-007 The module SHALL have port Blank_En, input, 1 bit: enables leading-zero suppression.
REQ-008 The module SHALL have port Dp_Mask, input, 4 bits: bit k=1 lights the dot point on digit k; sampled live, not staged.
REQ-009 The module SHALL have port An, output, 4 bits: anodes, active-low, bit k selects digit k.
REQ-010 The module SHALL have port Cathodes, output, 8 bits: {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low.
REQ-011 The module SHALL have port Pending, output, 1 bit: staged value not yet committed to the display.

Function
REQ-012 A free-running prescaler SHALL count 0 .. 2^SCAN_DIV_BITS-1 and wrap to 0; each wrap ends one digit slot.
REQ-013 Slot order SHALL be digit3, digit2, digit1, digit0, then repeat; the end of the digit0 slot is the frame boundary.
REQ-014 The slot FSM SHALL have two states: DEAD (prescaler < DEAD_CYC, An=4'b1111, Cathodes=8'hFF) and DRIVE (remaining cycles, exactly one An bit low).
REQ-015 An and Cathodes SHALL be registered; the first DEAD cycle of a slot SHALL appear at the outputs on the clock after the preceding slot's last cycle.
REQ-016 Load=1 SHALL write Digits into a stage register and set Pending on the next clock.
REQ-017 At the frame boundary, if Pending=1, the stage register SHALL be copied to the display shadow and Pending cleared; otherwise the shadow SHALL hold.
REQ-018 A Load on the frame-boundary cycle itself SHALL commit that cycle's Digits directly, leaving Pending=0.
REQ-019 A later Load before commit SHALL overwrite the stage register; only the last value is displayed.
REQ-020 The displayed digits SHALL never change mid-frame (no tearing).
REQ-021 Hex decode of abcdefg, active-low, SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-022 Dp SHALL be ~Dp_Mask[k] for the digit k being driven.
REQ-023 With Blank_En=1, digit k (k=3,2,1) SHALL be blanked (abcdefg=1111111, Dp still per mask) when it and all more-significant shadow digits are 0.
REQ-024 Digit0 SHALL never be blanked.

Reset
REQ-025 While Reset=1 the module SHALL set prescaler=0, the FSM to DEAD, the slot to digit3, stage=0, shadow=0, Pending=0, An=4'b1111 and Cathodes=8'hFF.
REQ-026 Reset asserted mid-slot or mid-Pending SHALL take effect on the next clock and discard the staged value.
REQ-027 After Reset deasserts, the first slot SHALL be digit3, starting in DEAD.

Verification (SCAN_DIV_BITS=4, DEAD_CYC=2)
REQ-028 The bench SHALL check that after Reset, with Load at 0, each 16-cycle slot shows 2 cycles with An=1111 then 14 cycles with An=0111, 1011, 1101, 1110 in turn, and Cathodes abcdefg=0000001 while driving.
REQ-029 The bench SHALL check that Load with Digits=16'h12AF mid-frame raises Pending, keeps the old digits until the frame boundary, then shows 1,2,A,F and drops Pending.
REQ-030 The bench SHALL check that Blank_En=1 with committed 16'h0050 blanks digits 3 and 2 and shows 5 then 0, and that 16'h0000 shows only digit0 as "0".
REQ-031 The bench SHALL check that Load with 16'h1111 followed by Load with 16'h2222 in the same frame displays only 2222.
REQ-032 The bench SHALL check that Load on the frame-boundary cycle with 16'h3456 commits at once, with Pending never set.
REQ-033 The bench SHALL check that Reset asserted for 1 cycle mid-DRIVE with Pending=1 gives An=1111, Cathodes=FF and Pending=0 on the next clock, followed by the digit3 slot showing 0.

Source files
------------

// File: rtl/ee354_ssd_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver with dead-time between digits,
// frame-synchronous digit commit (no tearing) and optional leading-zero blanking.
module ee354_ssd_scan_driver #(
  parameter int SCAN_DIV_BITS = 18,
  parameter int DEAD_CYC      = 256
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Load,
  input  logic [15:0] Digits,
  input  logic        Blank_En,
  input  logic [3:0]  Dp_Mask,
  output logic [3:0]  An,
  output logic [7:0]  Cathodes,
  output logic        Pending
);

  typedef enum logic {DEAD, DRIVE} slot_state_t;

  localparam logic [SCAN_DIV_BITS-1:0] PRESC_MAX = '1;
  localparam logic [SCAN_DIV_BITS-1:0] PRESC_ONE = SCAN_DIV_BITS'(1);
  localparam logic [SCAN_DIV_BITS-1:0] DEAD_LIM  = SCAN_DIV_BITS'(DEAD_CYC);

  logic [SCAN_DIV_BITS-1:0] presc_q, presc_d;
  logic [1:0]               slot_q, slot_d;
  slot_state_t              state_q, state_d;
  logic [15:0]              stage_q, stage_d;
  logic [15:0]              shadow_q, shadow_d;
  logic                     pending_q, pending_d;
  logic [3:0]               an_q, an_d;
  logic [7:0]               cath_q, cath_d;

  logic       wrap, frame_end;
  logic       zero3, zero2, zero1;
  logic [3:0] nib;
  logic       blank;
  logic [6:0] seg;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    case (hex)
      4'h0: hex_to_seg = 7'b0000001;
      4'h1: hex_to_seg = 7'b1001111;
      4'h2: hex_to_seg = 7'b0010010;
      4'h3: hex_to_seg = 7'b0000110;
      4'h4: hex_to_seg = 7'b1001100;
      4'h5: hex_to_seg = 7'b0100100;
      4'h6: hex_to_seg = 7'b0100000;
      4'h7: hex_to_seg = 7'b0001111;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0000100;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b1100000;
      4'hC: hex_to_seg = 7'b0110001;
      4'hD: hex_to_seg = 7'b1000010;
      4'hE: hex_to_seg = 7'b0110000;
      default: hex_to_seg = 7'b0111000;
    endcase
  endfunction

  // Outputs are registered from next-cycle values so An/Cathodes line up with the prescaler.
  always_comb begin
    presc_d   = presc_q + PRESC_ONE;
    wrap      = (presc_q == PRESC_MAX);
    frame_end = wrap && (slot_q == 2'd0);
    slot_d    = wrap ? slot_q - 2'd1 : slot_q;

    state_d = state_q;
    case (state_q)
      DEAD:  state_d = (presc_d >= DEAD_LIM) ? DRIVE : DEAD;
      DRIVE: state_d = wrap ? DEAD : DRIVE;
    endcase

    stage_d   = stage_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (frame_end) begin
      if (Load) begin
        shadow_d = Digits;
        stage_d  = Digits;
      end else if (pending_q) begin
        shadow_d = stage_q;
      end
      pending_d = 1'b0;
    end else if (Load) begin
      stage_d   = Digits;
      pending_d = 1'b1;
    end

    zero3 = (shadow_d[15:12] == 4'h0);
    zero2 = zero3 && (shadow_d[11:8] == 4'h0);
    zero1 = zero2 && (shadow_d[7:4] == 4'h0);

    nib   = shadow_d[3:0];
    blank = 1'b0;
    case (slot_d)
      2'd3: begin nib = shadow_d[15:12]; blank = Blank_En && zero3; end
      2'd2: begin nib = shadow_d[11:8];  blank = Blank_En && zero2; end
      2'd1: begin nib = shadow_d[7:4];   blank = Blank_En && zero1; end
      default: begin nib = shadow_d[3:0]; blank = 1'b0; end
    endcase
    seg = blank ? 7'b1111111 : hex_to_seg(nib);

    an_d   = 4'b1111;
    cath_d = 8'hFF;
    if (state_d == DRIVE) begin
      an_d   = ~(4'b0001 << slot_d);
      cath_d = {seg, ~Dp_Mask[slot_d]};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      presc_q   <= '0;
      slot_q    <= 2'd3;
      state_q   <= DEAD;
      stage_q   <= 16'h0000;
      shadow_q  <= 16'h0000;
      pending_q <= 1'b0;
      an_q      <= 4'b1111;
      cath_q    <= 8'hFF;
    end else begin
      presc_q   <= presc_d;
      slot_q    <= slot_d;
      state_q   <= state_d;
      stage_q   <= stage_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      cath_q    <= cath_d;
    end
  end

  assign An       = an_q;
  assign Cathodes = cath_q;
  assign Pending  = pending_q;

endmodule

// File: tb/tb_ee354_ssd_scan_driver.sv
// Directed bench for ee354_ssd_scan_driver with 16-cycle slots and 2 dead cycles,
// so one full frame is 64 clocks and pos tracks the frame position.
module tb_ee354_ssd_scan_driver;

  logic        Clk;
  logic        Reset;
  logic        Load;
  logic [15:0] Digits;
  logic        Blank_En;
  logic [3:0]  Dp_Mask;
  logic [3:0]  An;
  logic [7:0]  Cathodes;
  logic        Pending;

  int checks = 0;
  int errors = 0;
  int pos    = 0;

  logic [15:0] model_shadow;
  logic        model_blank;
  logic [3:0]  model_mask;

  ee354_ssd_scan_driver #(.SCAN_DIV_BITS(4), .DEAD_CYC(2)) dut (
    .Clk(Clk), .Reset(Reset), .Load(Load), .Digits(Digits),
    .Blank_En(Blank_En), .Dp_Mask(Dp_Mask),
    .An(An), .Cathodes(Cathodes), .Pending(Pending)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    case (h)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  function automatic logic [3:0] exp_an_at(input int p);
    logic [1:0] s;
    logic [3:0] one_hot;
    s = 2'(3 - p / 16);
    one_hot = 4'b0001 << s;
    if (p % 16 < 2) return 4'b1111;
    return ~one_hot;
  endfunction

  function automatic logic [7:0] exp_cath_at(input int p, input logic [15:0] d,
                                             input logic blank, input logic [3:0] mask);
    logic [1:0]  s;
    logic [15:0] upper;
    logic [6:0]  sg;
    s = 2'(3 - p / 16);
    if (p % 16 < 2) return 8'hFF;
    upper = d >> (4 * s);
    sg = (blank && s != 2'd0 && upper == 16'h0000) ? 7'b1111111 : seg_of(upper[3:0]);
    return {sg, ~mask[s]};
  endfunction

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
    pos = (pos + 1) % 64;
  endtask

  task automatic advance_to(input int target);
    for (int n = 0; n < 64 && pos != target; n++) step();
  endtask

  task automatic test_reset();
    Reset = 1'b1; Load = 1'b0; Digits = 16'h0000; Blank_En = 1'b0; Dp_Mask = 4'b0000;
    model_shadow = 16'h0000; model_blank = 1'b0; model_mask = 4'b0000;
    step();
    step();
    pos = 0;
    checks++;
    if (An !== 4'b1111) begin errors++; $display("[TB] FAIL reset_an: got %b expected 1111", An); end
    checks++;
    if (Cathodes !== 8'hFF) begin errors++; $display("[TB] FAIL reset_cath: got %h expected ff", Cathodes); end
    checks++;
    if (Pending !== 1'b0) begin errors++; $display("[TB] FAIL reset_pending: got %b expected 0", Pending); end
    Reset = 1'b0;
  endtask

  task automatic test_scan();
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (An !== exp_an_at(pos)) begin
        errors++; $display("[TB] FAIL scan_an pos=%0d: got %b expected %b", pos, An, exp_an_at(pos));
      end
      checks++;
      if (Cathodes !== exp_cath_at(pos, 16'h0000, 1'b0, 4'b0000)) begin
        errors++; $display("[TB] FAIL scan_cath pos=%0d: got %h expected %h", pos, Cathodes,
                           exp_cath_at(pos, 16'h0000, 1'b0, 4'b0000));
      end
      step();
    end
  endtask

  task automatic test_update();
    advance_to(20);
    Load = 1'b1; Digits = 16'h12AF;
    step();
    Load = 1'b0; Digits = 16'h0000;
    for (int n = 0; n < 64 && pos != 0; n++) begin
      checks++;
      if (Pending !== 1'b1) begin errors++; $display("[TB] FAIL update_pending_hi pos=%0d: got %b expected 1", pos, Pending); end
      checks++;
      if (Cathodes !== exp_cath_at(pos, model_shadow, model_blank, model_mask)) begin
        errors++; $display("[TB] FAIL update_old_cath pos=%0d: got %h expected %h", pos, Cathodes,
                           exp_cath_at(pos, model_shadow, model_blank, model_mask));
      end
      step();
    end
    checks++;
    if (Pending !== 1'b0) begin errors++; $display("[TB] FAIL update_pending_lo: got %b expected 0", Pending); end
    model_shadow = 16'h12AF;
    Dp_Mask = 4'b0101; model_mask = 4'b0101;
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (An !== exp_an_at(pos)) begin
        errors++; $display("[TB] FAIL update_an pos=%0d: got %b expected %b", pos, An, exp_an_at(pos));
      end
      checks++;
      if (Cathodes !== exp_cath_at(pos, model_shadow, model_blank, model_mask)) begin
        errors++; $display("[TB] FAIL update_cath pos=%0d: got %h expected %h", pos, Cathodes,
                           exp_cath_at(pos, model_shadow, model_blank, model_mask));
      end
      step();
    end
  endtask

  task automatic test_blank();
    logic [15:0] vals [2];
    vals[0] = 16'h0050;
    vals[1] = 16'h0000;
    Blank_En = 1'b1; model_blank = 1'b1;
    Dp_Mask = 4'b1000; model_mask = 4'b1000;
    for (int v = 0; v < 2; v++) begin
      advance_to(10);
      Load = 1'b1; Digits = vals[v];
      step();
      Load = 1'b0;
      advance_to(0);
      model_shadow = vals[v];
      for (int i = 0; i < 64; i++) begin
        checks++;
        if (Cathodes !== exp_cath_at(pos, model_shadow, model_blank, model_mask)) begin
          errors++; $display("[TB] FAIL blank_cath val=%h pos=%0d: got %h expected %h", vals[v], pos,
                             Cathodes, exp_cath_at(pos, model_shadow, model_blank, model_mask));
        end
        step();
      end
    end
    Blank_En = 1'b0; model_blank = 1'b0;
    Dp_Mask = 4'b0000; model_mask = 4'b0000;
  endtask

  task automatic test_back_to_back();
    advance_to(5);
    Load = 1'b1; Digits = 16'h1111;
    step();
    Load = 1'b0;
    checks++;
    if (Pending !== 1'b1) begin errors++; $display("[TB] FAIL b2b_pending_first: got %b expected 1", Pending); end
    advance_to(30);
    Load = 1'b1; Digits = 16'h2222;
    step();
    Load = 1'b0;
    checks++;
    if (Pending !== 1'b1) begin errors++; $display("[TB] FAIL b2b_pending_second: got %b expected 1", Pending); end
    advance_to(0);
    checks++;
    if (Pending !== 1'b0) begin errors++; $display("[TB] FAIL b2b_pending_lo: got %b expected 0", Pending); end
    model_shadow = 16'h2222;
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (Cathodes !== exp_cath_at(pos, model_shadow, model_blank, model_mask)) begin
        errors++; $display("[TB] FAIL b2b_cath pos=%0d: got %h expected %h", pos, Cathodes,
                           exp_cath_at(pos, model_shadow, model_blank, model_mask));
      end
      step();
    end
  endtask

  task automatic test_boundary_load();
    advance_to(63);
    checks++;
    if (Pending !== 1'b0) begin errors++; $display("[TB] FAIL bound_pending_pre: got %b expected 0", Pending); end
    Load = 1'b1; Digits = 16'h3456;
    step();
    Load = 1'b0; Digits = 16'h0000;
    model_shadow = 16'h3456;
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (Pending !== 1'b0) begin errors++; $display("[TB] FAIL bound_pending pos=%0d: got %b expected 0", pos, Pending); end
      checks++;
      if (Cathodes !== exp_cath_at(pos, model_shadow, model_blank, model_mask)) begin
        errors++; $display("[TB] FAIL bound_cath pos=%0d: got %h expected %h", pos, Cathodes,
                           exp_cath_at(pos, model_shadow, model_blank, model_mask));
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    advance_to(40);
    Load = 1'b1; Digits = 16'h789A;
    step();
    Load = 1'b0;
    checks++;
    if (Pending !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_pending_pre: got %b expected 1", Pending); end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    pos = 0;
    model_shadow = 16'h0000;
    checks++;
    if (An !== 4'b1111) begin errors++; $display("[TB] FAIL rstmid_an: got %b expected 1111", An); end
    checks++;
    if (Cathodes !== 8'hFF) begin errors++; $display("[TB] FAIL rstmid_cath: got %h expected ff", Cathodes); end
    checks++;
    if (Pending !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_pending: got %b expected 0", Pending); end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (An !== exp_an_at(pos)) begin
        errors++; $display("[TB] FAIL rstmid_scan_an pos=%0d: got %b expected %b", pos, An, exp_an_at(pos));
      end
      checks++;
      if (Cathodes !== exp_cath_at(pos, model_shadow, model_blank, model_mask)) begin
        errors++; $display("[TB] FAIL rstmid_scan_cath pos=%0d: got %h expected %h", pos, Cathodes,
                           exp_cath_at(pos, model_shadow, model_blank, model_mask));
      end
      step();
    end
    checks++;
    if (Pending !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_pending_end: got %b expected 0", Pending); end
  endtask

  initial begin
    $display("[TB] starting ee354_ssd_scan_driver bench");
    test_reset();
    test_scan();
    test_update();
    test_blank();
    test_back_to_back();
    test_boundary_load();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
